// File: rtl/handshake_pkg.sv
// Shared types and helpers for the handshake source/drain/FIFO family.
package handshake_pkg;

  typedef logic [31:0] cnt_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module handshake_fifo_mem #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic req/grt buffer stage with first-word fall-through and per-side transfer counters.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_req,
  output logic          up_grt,
  input  logic [DW-1:0] up_dat,
  output logic          dn_req,
  input  logic          dn_grt,
  output logic [DW-1:0] dn_dat,
  output logic [AW:0]   lvl,
  output cnt_t          cnt_in,
  output cnt_t          cnt_out
);

  localparam int unsigned PW = AW + 1;

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("handshake_fifo: DEPTH must be a power of two >= 2");
  end

  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  cnt_t          cnt_in_q, cnt_in_d, cnt_out_q, cnt_out_d;
  logic          empty, full, push, pop;
  logic [DW-1:0] rd_dat;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

  assign up_grt = ~full & ~rst;
  assign dn_req = ~empty;
  assign push   = up_req & up_grt;
  assign pop    = dn_req & dn_grt;

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_in_d  = cnt_in_q;
    cnt_out_d = cnt_out_q;
    if (push) begin
      wp_d     = wp_q + PW'(1);
      cnt_in_d = cnt_in_q + cnt_t'(1);
    end
    if (pop) begin
      rp_d      = rp_q + PW'(1);
      cnt_out_d = cnt_out_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_in_q  <= cnt_in_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  handshake_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp_q[AW-1:0]),
    .wdata (up_dat),
    .raddr (rp_q[AW-1:0]),
    .rdata (rd_dat)
  );

  // Stale array contents are masked so an empty FIFO always shows zero.
  assign dn_dat  = empty ? '0 : rd_dat;
  assign lvl     = wp_q - rp_q;
  assign cnt_in  = cnt_in_q;
  assign cnt_out = cnt_out_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized scoreboard bench for handshake_fifo against a queue-based reference model.
module tb_handshake_fifo;
  import handshake_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_req, up_grt, dn_req, dn_grt;
  logic [DW-1:0] up_dat, dn_dat;
  logic [AW:0]   lvl;
  cnt_t          cnt_in, cnt_out;

  always #5 clk = ~clk;

  handshake_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .up_req  (up_req),
    .up_grt  (up_grt),
    .up_dat  (up_dat),
    .dn_req  (dn_req),
    .dn_grt  (dn_grt),
    .dn_dat  (dn_dat),
    .lvl     (lvl),
    .cnt_in  (cnt_in),
    .cnt_out (cnt_out)
  );

  // Reference model: words accepted but not yet delivered, plus occupancy and counters.
  logic [DW-1:0] exp_q[$];
  int unsigned   mdl_lvl = 0;
  cnt_t          mdl_cin = '0, mdl_cout = '0;

  // Expectations for the cycle currently being driven (read by the monitor).
  int unsigned   exp_lvl = 0;
  cnt_t          exp_cin = '0, exp_cout = '0;
  logic          exp_grt = 1'b0;
  logic [DW-1:0] hd;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle, publish expectations for it, then apply the handshake rules to the model.
  task automatic cyc(input logic r, input logic ur, input logic [DW-1:0] ud, input logic dg);
    bit push, pop;
    rst    = r;
    up_req = ur;
    up_dat = ud;
    dn_grt = dg;
    if (r) begin
      exp_q.delete();
      mdl_lvl  = 0;
      mdl_cin  = '0;
      mdl_cout = '0;
    end
    exp_lvl  = mdl_lvl;
    exp_cin  = mdl_cin;
    exp_cout = mdl_cout;
    exp_grt  = !r && (mdl_lvl < DEPTH);
    push = !r && ur && (mdl_lvl < DEPTH);
    pop  = !r && dg && (mdl_lvl > 0);
    if (push) begin
      exp_q.push_back(ud);
      mdl_cin++;
    end
    if (pop) mdl_cout++;
    mdl_lvl = mdl_lvl + (push ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare DUT outputs mid-cycle and retire the head word on a downstream transfer.
  always @(negedge clk) begin
    hd = (exp_lvl > 0 && exp_q.size() > 0) ? exp_q[0] : '0;
    chk("up_grt",  32'(up_grt), 32'(exp_grt));
    chk("dn_req",  32'(dn_req), 32'(exp_lvl > 0));
    chk("lvl",     32'(lvl),    exp_lvl);
    chk("cnt_in",  cnt_in,      exp_cin);
    chk("cnt_out", cnt_out,     exp_cout);
    chk("dn_dat",  32'(dn_dat), 32'(hd));
    chk("cnt_diff_vs_lvl", cnt_in - cnt_out, 32'(lvl));
    if (!rst && dn_grt && exp_lvl > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  initial begin
    logic [DW-1:0] fill_pat [4];
    int unsigned   pr, pg;
    fill_pat[0] = 8'h11; fill_pat[1] = 8'h22; fill_pat[2] = 8'h33; fill_pat[3] = 8'h44;

    // Reset held, including a request that must not be accepted.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b1);

    // Fill to full, then offer one more word that must be refused.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, fill_pat[i], 1'b0);
    cyc(1'b0, 1'b1, 8'h55, 1'b0);

    // Drain in order, then grant while empty.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Level 2, then 10 cycles of simultaneous push and pop.
    cyc(1'b0, 1'b1, 8'hA1, 1'b0);
    cyc(1'b0, 1'b1, 8'hA2, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b1);

    // Top up to full, then push+pop while full: only the pop happens.
    cyc(1'b0, 1'b1, 8'hB1, 1'b0);
    cyc(1'b0, 1'b1, 8'hB2, 1'b0);
    cyc(1'b0, 1'b1, 8'h99, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset with three words stored.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Random source/drain stalls with shifting bias.
    for (int i = 0; i < 1000; i++) begin
      pr = (i < 500) ? 75 : 35;
      pg = (i < 500) ? 35 : 75;
      cyc(1'b0, 1'($urandom_range(0, 99) < pr), 8'($urandom), 1'($urandom_range(0, 99) < pg));
    end

    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
